ecc_decoder: RTL and testbench
==============================

// Module: ecc_decoder
// PURPOSE
//  Receive-side counterpart of the codeword encoder: takes an 8/16/32-bit right-aligned codeword, computes its syndrome,
//  corrects any single-bit error, flags uncorrectable errors and returns right-aligned data (4/11/26 bits).
//  Two-stage valid/ready pipeline between the register-file data path and the APB-visible result/counters.
// PARAMETERS
//  AMBA_WORD  32  codeword/data bus width (fixed; narrower codes are zero-padded on the MSB side)
//  CNT_WIDTH  16  width of the saturating error counters
// PORTS
//  clk             in   1          clock
//  rst             in   1          reset, asynchronous, active-low
//  din_valid       in   1          codeword present on din
//  din_ready       out  1          decoder accepts din this cycle
//  codeword_width  in   2          00 small(8b) 01 medium(16b) 10 large(32b) 11 treated as large
//  din             in   AMBA_WORD  received codeword, right-aligned, unused MSBs ignored
//  dout_valid      out  1          result present
//  dout_ready      in   1          consumer takes result this cycle
//  dout            out  AMBA_WORD  corrected data, right-aligned, upper bits 0
//  num_of_errors   out  2          00 none, 01 single corrected, 10 uncorrectable
//  cnt_clr         in   1          synchronous clear of both counters
//  corr_cnt        out  CNT_WIDTH  count of words with num_of_errors=01
//  uncorr_cnt      out  CNT_WIDTH  count of words with num_of_errors=10
// BEHAVIOUR
//  Code: syndrome bit i = ^(cw & MASK_i); MSB = first parity row. Column j = {MASK_i[j]} over all rows.
//   small  (cw[7:0], data cw[7:4], parity cw[3:0]):   78 E4 D2 B1
//   medium (cw[15:0], data cw[15:5], parity cw[4:0]): 96F0 FE08 F1C4 CDA2 AB61
//   large  (cw[31:0], data cw[31:6], parity cw[5:0]): 6987_21E0 FFFE_0010 FF01_FC08 F0F1_E384 CCCD_9F42 AAAB_56C1
//  Classification: syndrome 0 -> 00, data unchanged. Syndrome equals exactly one column j -> flip cw[j], 01
//   (parity-bit hit leaves data unchanged, still 01). Nonzero, no match or >1 match -> 10, data passed uncorrected.
//  Stage 1 (accept): on din_valid&din_ready register masked cw, width, syndrome; s1_valid<=1.
//  Stage 2: on s1_valid & advance register corrected data, num_of_errors; dout_valid<=1.
//  advance = ~dout_valid | dout_ready; din_ready = ~s1_valid | advance (combinational, no comb path din->dout).
//  Latency: accept in cycle N -> dout_valid in N+2 when no back-pressure; full throughput 1 word/cycle.
//  While dout_valid & ~dout_ready: dout, num_of_errors, dout_valid held stable; stage 1 holds; din_ready=0 when both full.
//  dout_valid drops after a dout_ready handshake unless stage 1 delivers a new word in the same cycle.
//  Width is latched per word; changing codeword_width mid-pipeline affects only later accepts.
//  Counters increment once per dout handshake (dout_valid&dout_ready) by class; saturate at all-ones, no wrap.
//  cnt_clr has priority over same-cycle increment (result 0).
//  Reset (any time, incl. mid-transfer): dout_valid=0, s1_valid=0, dout=0, num_of_errors=00, counters=0;
//   in-flight words discarded; din_ready=1 from first cycle after rst deasserts.
// TESTING
//  small din=0x000000AA, width 00 -> dout=0x0000000A, errs 00, dout_valid exactly 2 cycles after accept.
//  small din=0xEA (bit6 flipped) -> dout=0xA, errs 01, corr_cnt 0->1; din=0x2B (bits7,0) -> dout=0x2, errs 10, uncorr_cnt+1.
//  medium din=0x0001 -> dout=0, errs 01; din=0x0003 -> errs 10; din=0x0000 -> dout=0, errs 00.
//  large back-to-back 4 words, dout_ready low 3 cycles -> din_ready low after 2 accepts, outputs stable, no loss/reorder.
//  preload corr_cnt to 0xFFFE via 2 extra words... (force) then 3 corrected words -> saturates 0xFFFF; cnt_clr+hit -> 0.
//  rst low with both stages full -> dout_valid=0, counters 0 next edge; next word decodes normally.

Source files
------------

// File: rtl/ecc_decoder.sv
// Syndrome-based single-error-correcting decoder for 8/16/32-bit right-aligned codewords,
// with a two-stage valid/ready pipeline and saturating corrected/uncorrectable word counters.
module ecc_decoder #(
    parameter int AMBA_WORD = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic [1:0]           codeword_width,
    input  logic [AMBA_WORD-1:0] din,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [AMBA_WORD-1:0] dout,
    output logic [1:0]           num_of_errors,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] corr_cnt,
    output logic [CNT_WIDTH-1:0] uncorr_cnt
);

    localparam logic [1:0] W_SMALL    = 2'b00;
    localparam logic [1:0] W_MEDIUM   = 2'b01;
    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_CORR   = 2'b01;
    localparam logic [1:0] ERR_UNCORR = 2'b10;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Parity row r of the code selected by w; row index r maps to syndrome bit r (top row = MSB).
    function automatic logic [31:0] row_mask(input logic [1:0] w, input logic [2:0] r);
        logic [31:0] m;
        m = 32'h0000_0000;
        case (w)
            W_SMALL: begin
                case (r)
                    3'd3:    m = 32'h0000_0078;
                    3'd2:    m = 32'h0000_00E4;
                    3'd1:    m = 32'h0000_00D2;
                    3'd0:    m = 32'h0000_00B1;
                    default: m = 32'h0000_0000;
                endcase
            end
            W_MEDIUM: begin
                case (r)
                    3'd4:    m = 32'h0000_96F0;
                    3'd3:    m = 32'h0000_FE08;
                    3'd2:    m = 32'h0000_F1C4;
                    3'd1:    m = 32'h0000_CDA2;
                    3'd0:    m = 32'h0000_AB61;
                    default: m = 32'h0000_0000;
                endcase
            end
            default: begin
                case (r)
                    3'd5:    m = 32'h6987_21E0;
                    3'd4:    m = 32'hFFFE_0010;
                    3'd3:    m = 32'hFF01_FC08;
                    3'd2:    m = 32'hF0F1_E384;
                    3'd1:    m = 32'hCCCD_9F42;
                    3'd0:    m = 32'hAAAB_56C1;
                    default: m = 32'h0000_0000;
                endcase
            end
        endcase
        return m;
    endfunction

    function automatic logic [31:0] width_mask(input logic [1:0] w);
        logic [31:0] m;
        case (w)
            W_SMALL:  m = 32'h0000_00FF;
            W_MEDIUM: m = 32'h0000_FFFF;
            default:  m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    // Unused rows of the narrower codes are all-zero, so their syndrome bits stay 0.
    function automatic logic [5:0] calc_syndrome(input logic [31:0] cw, input logic [1:0] w);
        logic [5:0] syn;
        syn = 6'd0;
        for (int r = 0; r < 6; r++) begin
            syn[r] = ^(cw & row_mask(w, r[2:0]));
        end
        return syn;
    endfunction

    function automatic logic [5:0] column(input logic [1:0] w, input logic [4:0] j);
        logic [5:0]  col;
        logic [31:0] m;
        col = 6'd0;
        for (int r = 0; r < 6; r++) begin
            m      = row_mask(w, r[2:0]);
            col[r] = m[j];
        end
        return col;
    endfunction

    function automatic logic [31:0] extract_data(input logic [31:0] cw, input logic [1:0] w);
        logic [31:0] d;
        case (w)
            W_SMALL:  d = {28'd0, cw[7:4]};
            W_MEDIUM: d = {21'd0, cw[15:5]};
            default:  d = {6'd0, cw[31:6]};
        endcase
        return d;
    endfunction

    logic        s1_valid_r;
    logic [31:0] s1_cw_r;
    logic [1:0]  s1_width_r;
    logic [5:0]  s1_syn_r;

    logic                 dout_valid_r;
    logic [31:0]          dout_r;
    logic [1:0]           err_r;
    logic [CNT_WIDTH-1:0] corr_cnt_r;
    logic [CNT_WIDTH-1:0] uncorr_cnt_r;

    logic                 advance_s;
    logic                 accept_s;
    logic                 handshake_s;
    logic [31:0]          masked_cw_s;
    logic [31:0]          flip_s;
    logic [31:0]          data_s;
    logic [1:0]           err_s;
    logic [CNT_WIDTH-1:0] corr_next_s;
    logic [CNT_WIDTH-1:0] uncorr_next_s;

    assign advance_s   = ~dout_valid_r | dout_ready;
    assign din_ready   = ~s1_valid_r | advance_s;
    assign accept_s    = din_valid & din_ready;
    assign handshake_s = dout_valid_r & dout_ready;
    assign masked_cw_s = din[31:0] & width_mask(codeword_width);

    // Stage 1: capture the masked codeword, its width and its syndrome.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_cw_r    <= 32'd0;
            s1_width_r <= 2'b00;
            s1_syn_r   <= 6'd0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_cw_r    <= masked_cw_s;
            s1_width_r <= codeword_width;
            s1_syn_r   <= calc_syndrome(masked_cw_s, codeword_width);
        end else if (advance_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Column matching: a single matching column pinpoints the flipped bit; none or several is uncorrectable.
    always_comb begin
        flip_s = 32'd0;
        data_s = 32'd0;
        err_s  = ERR_NONE;
        for (int j = 0; j < 32; j++) begin
            flip_s[j] = (s1_syn_r != 6'd0) && (column(s1_width_r, j[4:0]) == s1_syn_r);
        end
        if (s1_syn_r == 6'd0) begin
            err_s  = ERR_NONE;
            data_s = extract_data(s1_cw_r, s1_width_r);
        end else if ($onehot(flip_s)) begin
            err_s  = ERR_CORR;
            data_s = extract_data(s1_cw_r ^ flip_s, s1_width_r);
        end else begin
            err_s  = ERR_UNCORR;
            data_s = extract_data(s1_cw_r, s1_width_r);
        end
    end

    // Stage 2: result register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_valid_r <= 1'b0;
            dout_r       <= 32'd0;
            err_r        <= ERR_NONE;
        end else if (advance_s) begin
            dout_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                dout_r <= data_s;
                err_r  <= err_s;
            end
        end
    end

    // Counter next-state: clear wins over a same-cycle increment; both saturate at all-ones.
    always_comb begin
        corr_next_s   = corr_cnt_r;
        uncorr_next_s = uncorr_cnt_r;
        if (cnt_clr) begin
            corr_next_s   = {CNT_WIDTH{1'b0}};
            uncorr_next_s = {CNT_WIDTH{1'b0}};
        end else if (handshake_s && (err_r == ERR_CORR) && (corr_cnt_r != CNT_MAX)) begin
            corr_next_s = corr_cnt_r + CNT_ONE;
        end else if (handshake_s && (err_r == ERR_UNCORR) && (uncorr_cnt_r != CNT_MAX)) begin
            uncorr_next_s = uncorr_cnt_r + CNT_ONE;
        end else begin
            corr_next_s   = corr_cnt_r;
            uncorr_next_s = uncorr_cnt_r;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            corr_cnt_r   <= {CNT_WIDTH{1'b0}};
            uncorr_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            corr_cnt_r   <= corr_next_s;
            uncorr_cnt_r <= uncorr_next_s;
        end
    end

    assign dout_valid    = dout_valid_r;
    assign dout          = dout_r;
    assign num_of_errors = err_r;
    assign corr_cnt      = corr_cnt_r;
    assign uncorr_cnt    = uncorr_cnt_r;

endmodule

// File: tb/tb_ecc_decoder.sv
// Scoreboard bench for ecc_decoder: expected results queue on accept, compared at each dout handshake.
module tb_ecc_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        din_valid;
    logic        din_ready;
    logic [1:0]  codeword_width;
    logic [31:0] din;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout;
    logic [1:0]  num_of_errors;
    logic        cnt_clr;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;

    ecc_decoder #(.AMBA_WORD(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .din_valid(din_valid), .din_ready(din_ready),
        .codeword_width(codeword_width), .din(din),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout(dout), .num_of_errors(num_of_errors),
        .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  e;
        bit          lat;
        int          cyc;
    } exp_t;

    exp_t pend_q[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    logic [15:0] exp_corr = 16'd0;
    logic [15:0] exp_unc  = 16'd0;

    localparam bit [31:0] SM_ROWS [4] = '{32'h78, 32'hE4, 32'hD2, 32'hB1};
    localparam bit [31:0] MD_ROWS [5] = '{32'h96F0, 32'hFE08, 32'hF1C4, 32'hCDA2, 32'hAB61};
    localparam bit [31:0] LG_ROWS [6] = '{32'h6987_21E0, 32'hFFFE_0010, 32'hFF01_FC08,
                                          32'hF0F1_E384, 32'hCCCD_9F42, 32'hAAAB_56C1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%08h, need 0x%08h (t=%0t)", tag, act, req, $time);
    endtask

    // Reference: a word is valid when every parity row has even parity over it.
    function automatic bit m_is_cw(input logic [1:0] w, input logic [31:0] cw);
        bit ok = 1'b1;
        case (w)
            2'b00:   foreach (SM_ROWS[r]) if (^(cw & SM_ROWS[r])) ok = 1'b0;
            2'b01:   foreach (MD_ROWS[r]) if (^(cw & MD_ROWS[r])) ok = 1'b0;
            default: foreach (LG_ROWS[r]) if (^(cw & LG_ROWS[r])) ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Reference decode: search every single-bit flip that yields a valid word.
    function automatic void m_decode(input logic [1:0] w, input logic [31:0] raw,
                                     output logic [31:0] d, output logic [1:0] e);
        int nb, sh, hits;
        logic [31:0] cw, fix, one;
        case (w)
            2'b00:   begin nb = 8;  sh = 4; cw = raw & 32'h0000_00FF; end
            2'b01:   begin nb = 16; sh = 5; cw = raw & 32'h0000_FFFF; end
            default: begin nb = 32; sh = 6; cw = raw; end
        endcase
        hits = 0;
        fix  = cw;
        if (m_is_cw(w, cw)) begin
            e = 2'b00; d = cw >> sh;
        end else begin
            for (int j = 0; j < nb; j++) begin
                one = 32'd1 << j;
                if (m_is_cw(w, cw ^ one)) begin hits++; fix = cw ^ one; end
            end
            if (hits == 1) begin e = 2'b01; d = fix >> sh; end
            else begin e = 2'b10; d = cw >> sh; end
        end
    endfunction

    task automatic send(input logic [1:0] w, input logic [31:0] cw,
                        input logic [31:0] ed, input logic [1:0] ee, input bit lat);
        exp_t x;
        bit   ok;
        int   n;
        x.d = ed; x.e = ee; x.lat = lat; x.cyc = 0;
        pend_q.push_back(x);
        codeword_width = w; din = cw; din_valid = 1'b1;
        ok = 1'b0; n = 0;
        while (!ok && n < 60) begin
            @(negedge clk); ok = din_ready;
            @(posedge clk); #1; n++;
        end
        din_valid = 1'b0;
        if (!ok) begin
            check_val("accept_timeout", 32'd0, 32'd1);
            pend_q.delete();
        end
    endtask

    task automatic send_m(input logic [1:0] w, input logic [31:0] cw);
        logic [31:0] d;
        logic [1:0]  e;
        m_decode(w, cw, d, e);
        send(w, cw, d, e, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) check_val("drain_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_dout_valid(input string tag);
        int n = 0;
        @(negedge clk);
        while (!dout_valid && n < 20) begin @(negedge clk); n++; end
        check_val(tag, {31'd0, dout_valid}, 32'd1);
    endtask

    // Monitor: scoreboard compare, counter model, stability under back-pressure.
    initial begin : monitor
        exp_t        x;
        bit          prev_stall = 1'b0;
        logic [31:0] prev_dout  = 32'd0;
        logic [1:0]  prev_err   = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sb_q.delete(); pend_q.delete();
                exp_corr = 16'd0; exp_unc = 16'd0; prev_stall = 1'b0;
            end else begin
                check_val("corr_cnt", {16'd0, corr_cnt}, {16'd0, exp_corr});
                check_val("uncorr_cnt", {16'd0, uncorr_cnt}, {16'd0, exp_unc});
                if (prev_stall) begin
                    check_val("hold_valid", {31'd0, dout_valid}, 32'd1);
                    check_val("hold_dout", dout, prev_dout);
                    check_val("hold_errs", {30'd0, num_of_errors}, {30'd0, prev_err});
                end
                if (dout_valid && dout_ready) begin
                    if (sb_q.size() == 0) begin
                        check_val("spurious_dout", 32'd1, 32'd0);
                    end else begin
                        x = sb_q.pop_front();
                        check_val("dout", dout, x.d);
                        check_val("errs", {30'd0, num_of_errors}, {30'd0, x.e});
                        if (x.lat) check_val("latency", cyc - x.cyc, 32'd2);
                        if (x.e == 2'b01 && exp_corr != 16'hFFFF) exp_corr = exp_corr + 16'd1;
                        if (x.e == 2'b10 && exp_unc != 16'hFFFF) exp_unc = exp_unc + 16'd1;
                    end
                end
                if (cnt_clr) begin exp_corr = 16'd0; exp_unc = 16'd0; end
                if (din_valid && din_ready && pend_q.size() > 0) begin
                    x = pend_q.pop_front();
                    x.cyc = cyc;
                    sb_q.push_back(x);
                end
                prev_stall = dout_valid && !dout_ready;
                prev_dout  = dout;
                prev_err   = num_of_errors;
            end
        end
    end

    initial begin : stimulus
        logic [31:0] rw;
        rst = 1'b0; din_valid = 1'b0; dout_ready = 1'b1; cnt_clr = 1'b0;
        din = 32'd0; codeword_width = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
        check_val("rst_dout", dout, 32'd0);
        check_val("rst_errs", {30'd0, num_of_errors}, 32'd0);
        check_val("rst_counters", {corr_cnt, uncorr_cnt}, 32'd0);
        rst = 1'b1;
        #1;
        check_val("rst_din_ready", {31'd0, din_ready}, 32'd1);
        @(posedge clk); #1;

        // Small code: clean, single data-bit error, double error, ignored upper bits
        send(2'b00, 32'h0000_00AA, 32'h0000_000A, 2'b00, 1'b1);
        send(2'b00, 32'h0000_00EA, 32'h0000_000A, 2'b01, 1'b0);
        send(2'b00, 32'h0000_002B, 32'h0000_0002, 2'b10, 1'b0);
        send(2'b00, 32'hFFFF_FFAA, 32'h0000_000A, 2'b00, 1'b0);
        drain();
        check_val("small_corr_cnt", {16'd0, corr_cnt}, 32'd1);
        check_val("small_uncorr_cnt", {16'd0, uncorr_cnt}, 32'd1);

        // Medium code: parity-bit hit, double error, clean zero
        send(2'b01, 32'h0000_0001, 32'd0, 2'b01, 1'b0);
        send(2'b01, 32'h0000_0003, 32'd0, 2'b10, 1'b0);
        send(2'b01, 32'h0000_0000, 32'd0, 2'b00, 1'b0);
        drain();

        // Large code back-to-back under back-pressure
        dout_ready = 1'b0;
        fork
            begin
                send_m(2'b10, 32'h0000_0000);
                send_m(2'b10, 32'h8000_0000);
                send_m(2'b10, 32'h0000_0003);
                send_m(2'b11, 32'hDEAD_BEEF);
            end
            begin
                wait_dout_valid("stall_dout_valid");
                check_val("din_ready_full", {31'd0, din_ready}, 32'd0);
                repeat (3) @(posedge clk);
                #1 dout_ready = 1'b1;
            end
        join
        drain();

        // Random widths, sparse/dense words, random consumer stalls
        fork
            for (int i = 0; i < 40; i++) begin
                case ($urandom_range(0, 2))
                    0:       rw = $urandom();
                    1:       rw = 32'd1 << $urandom_range(0, 31);
                    default: rw = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31));
                endcase
                send_m(2'($urandom_range(0, 3)), rw);
            end
            begin
                repeat (150) begin
                    @(posedge clk); #1 dout_ready = ($urandom_range(0, 3) != 0);
                end
                dout_ready = 1'b1;
            end
        join
        dout_ready = 1'b1;
        drain();

        // Saturation of the corrected-word counter
        force dut.corr_cnt_r = 16'hFFFE;
        exp_corr = 16'hFFFE;
        @(posedge clk); #1;
        release dut.corr_cnt_r;
        @(posedge clk); #1;
        check_val("preload", {16'd0, corr_cnt}, 32'h0000_FFFE);
        send_m(2'b00, 32'h0000_00EA);
        send_m(2'b01, 32'h0000_0001);
        send_m(2'b10, 32'h8000_0000);
        drain();
        check_val("corr_saturated", {16'd0, corr_cnt}, 32'h0000_FFFF);

        // Clear coincident with a corrected-word handshake
        dout_ready = 1'b0;
        send(2'b00, 32'h0000_00EA, 32'h0000_000A, 2'b01, 1'b0);
        wait_dout_valid("clr_dout_valid");
        @(posedge clk); #1;
        dout_ready = 1'b1; cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        check_val("clr_corr", {16'd0, corr_cnt}, 32'd0);
        check_val("clr_uncorr", {16'd0, uncorr_cnt}, 32'd0);

        // Reset with both stages full
        send(2'b00, 32'h0000_002B, 32'h0000_0002, 2'b10, 1'b0);
        drain();
        dout_ready = 1'b0;
        send_m(2'b10, 32'h0000_0000);
        send_m(2'b10, 32'h0000_0001);
        rst = 1'b0;
        #1;
        check_val("midrst_dout_valid", {31'd0, dout_valid}, 32'd0);
        check_val("midrst_dout", dout, 32'd0);
        check_val("midrst_errs", {30'd0, num_of_errors}, 32'd0);
        check_val("midrst_counters", {corr_cnt, uncorr_cnt}, 32'd0);
        check_val("midrst_din_ready", {31'd0, din_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; dout_ready = 1'b1;
        send(2'b00, 32'h0000_00EA, 32'h0000_000A, 2'b01, 1'b1);
        drain();
        check_val("post_rst_corr", {16'd0, corr_cnt}, 32'd1);
        check_val("scoreboard_empty", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
